if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch front end and PC generator. Drives `if_pc`/`if_inst` into the IF/ID pipeline register.
- Master on the SRAM-like instruction bus: `ibus_req_o` is held with a stable address until `ibus_ack_i`.
- Applies pipeline stall, flush (exception redirect) and delayed-branch redirect to the PC.
- Raises `stallreq_o` to the pipeline controller while a fetch is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- stall  in  6  pipeline stall vector; bit0 = PC stage, bit2 = ID stage; 1 = Stop
- flush  in  1  exception flush; redirect to new_pc
- new_pc  in  32  exception handler address
- branch_flag_i  in  1  ID-stage branch taken
- branch_target_address_i  in  32  branch target from ID
- ibus_data_i  in  32  instruction read data, valid with ack
- ibus_ack_i  in  1  bus completion, single-cycle pulse
- ibus_req_o  out  1  bus request
- ibus_addr_o  out  32  fetch address (word aligned in normal use)
- if_pc  out  32  PC of instruction presented to IF/ID
- if_inst  out  32  instruction presented to IF/ID
- stallreq_o  out  1  fetch-not-ready stall request

Behaviour:
- Reset (rst==0, async):
  - state=IDLE, pc=RESET_PC, branch pending cleared.
  - All outputs 0.
- States: IDLE, FETCH, HOLD, DISCARD.
- IDLE:
  - req=0, stallreq=0, if_pc=0, if_inst=0.
  - Next edge goes to FETCH. IDLE is entered only from reset.
- FETCH:
  - req=1, addr=pc.
  - No ack: stallreq=1, if_pc=0, if_inst=0.
  - Ack: if_pc=pc, if_inst=ibus_data_i (combinational), stallreq=0.
  - On ack with stall[0]==0: pc<=next_pc; remain in FETCH. The next request issues the following cycle; zero idle cycles with a 1-cycle-ack memory.
  - On ack with stall[0]==1: capture data in hold_inst; go to HOLD.
- HOLD:
  - req=0, stallreq=0, if_pc=pc, if_inst=hold_inst.
  - When stall[0]==0: pc<=next_pc, go to FETCH.
- next_pc, priority order:
  1. branch_flag_i ? branch_target_address_i
  2. pend_valid ? pend_tgt
  3. pc+4, 32-bit wrap (32'hFFFF_FFFC -> 0)
  - Consuming a branch clears pend_valid.
- Branch latch:
  - If branch_flag_i==1 and stall[2]==0 and the PC does not advance this cycle: pend_valid<=1, pend_tgt<=target.
  - This preserves delay-slot semantics; the target applies after the current (delay-slot) fetch.
- Flush (highest priority, any state except IDLE):
  - pc<=new_pc, pend_valid<=0.
  - From FETCH without ack in the same cycle: go to DISCARD.
  - Otherwise (FETCH with ack, or HOLD): go to FETCH.
- DISCARD:
  - req=1 and addr held at the old address; the bus protocol forbids dropping req.
  - stallreq=1, if_pc=0, if_inst=0.
  - On ack: data dropped, go to FETCH at the redirected pc.
  - A second flush in DISCARD updates pc only.
- Reset asserted mid-request: immediate return to IDLE with req=0. The bus must tolerate the abandoned request.
- ibus_addr_o and req are stable from request to ack in all states.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Defined:
  - Adds output port `if_excepttype_o` (1 bit, address-error-on-fetch).
  - In FETCH with pc[1:0]!=0: no bus request (req=0), stallreq=0, if_pc=pc, if_inst=0, if_excepttype_o=1.
  - PC then advances or holds per stall as if acked. Exception handling relies on a later flush.
  - if_excepttype_o=0 otherwise; reset value 0.
- Undefined:
  - Port absent; no check.
  - Misaligned pc is issued on the bus unmodified.

Test Plan:
- Reset release, memory acks 1 cycle after req, stall=0 -> addrs 0x0, 0x4, 0x8 on consecutive requests; if_pc/if_inst match on ack cycles; stallreq high only in no-ack cycles.
- Ack delayed 3 cycles at pc=0x10 -> stallreq=1 for 3 cycles, req/addr=0x10 stable; if_inst=data on the ack cycle.
- Ack while stall=6'b000011 for 2 cycles -> HOLD, req=0, if_inst held; after release next addr=0x14.
- branch_flag_i=1, target=0x100 while fetching delay slot at 0x24 (ack delayed 2 cycles) -> 0x24 completes, next addr=0x100, never 0x28.
- Flush with new_pc=0x80 during an outstanding fetch at 0x30 -> DISCARD, addr 0x30 held to ack, data not presented; next addr=0x80.
- IF_ALIGN_CHECK_EN defined, branch to 0x102 -> no req at 0x102, if_excepttype_o=1, if_pc=0x102, if_inst=0.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC generator and SRAM-like bus master feeding IF/ID.
// Optional IF_ALIGN_CHECK_EN adds if_excepttype_o and suppresses misaligned fetches.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  input  logic [31:0] ibus_data_i,
  input  logic        ibus_ack_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_o
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        if_excepttype_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_pend_valid;
  logic [31:0] r_pend_tgt;
  logic [31:0] r_hold_inst;
  logic [31:0] r_disc_addr;

  logic        w_misalign;
  logic        w_done;
  logic        w_advance;
  logic        w_latch;
  logic [31:0] w_next_pc;
  logic        w_exc;
  logic        w_unused;

  assign w_unused = ^{stall[5:3], stall[1]};

`ifdef IF_ALIGN_CHECK_EN
  assign w_misalign = (r_pc[1:0] != 2'b00);
  assign if_excepttype_o = w_exc;
`else
  assign w_misalign = 1'b0;
`endif

  // A misaligned fetch completes immediately without touching the bus.
  assign w_done    = (r_state == S_FETCH) && (ibus_ack_i || w_misalign);
  assign w_advance = !stall[0] && (w_done || (r_state == S_HOLD));
  // Branch seen while the delay-slot fetch is still pending is remembered for later.
  assign w_latch   = branch_flag_i && !stall[2] && !w_advance && !flush
                     && (r_state != S_IDLE);

  // Next PC selection: live branch, then remembered branch, then sequential.
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (branch_flag_i) begin
      w_next_pc = branch_target_address_i;
    end else if (r_pend_valid) begin
      w_next_pc = r_pend_tgt;
    end else begin
      w_next_pc = r_pc + 32'd4;
    end
  end

  // Fetch state machine, PC and pending-branch registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_pend_valid <= 1'b0;
      r_pend_tgt   <= 32'h0000_0000;
      r_hold_inst  <= 32'h0000_0000;
      r_disc_addr  <= 32'h0000_0000;
    end else begin
      if (w_latch) begin
        r_pend_valid <= 1'b1;
        r_pend_tgt   <= branch_target_address_i;
      end
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (flush) begin
            r_pc         <= new_pc;
            r_pend_valid <= 1'b0;
            if (w_done) begin
              r_state <= S_FETCH;
            end else begin
              r_state     <= S_DISCARD;
              r_disc_addr <= r_pc;
            end
          end else if (w_done) begin
            if (!stall[0]) begin
              r_pc         <= w_next_pc;
              r_pend_valid <= 1'b0;
            end else begin
              r_hold_inst <= w_misalign ? 32'h0000_0000 : ibus_data_i;
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (flush) begin
            r_pc         <= new_pc;
            r_pend_valid <= 1'b0;
            r_state      <= S_FETCH;
          end else if (!stall[0]) begin
            r_pc         <= w_next_pc;
            r_pend_valid <= 1'b0;
            r_state      <= S_FETCH;
          end
        end
        S_DISCARD: begin
          // The abandoned request must still run to its ack before re-issuing.
          if (flush) begin
            r_pc         <= new_pc;
            r_pend_valid <= 1'b0;
          end
          if (ibus_ack_i) begin
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Bus and IF/ID outputs; ack data passes straight through to IF/ID.
  always_comb begin
    ibus_req_o  = 1'b0;
    ibus_addr_o = 32'h0000_0000;
    if_pc       = 32'h0000_0000;
    if_inst     = 32'h0000_0000;
    stallreq_o  = 1'b0;
    w_exc       = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_misalign) begin
          if_pc = r_pc;
          w_exc = 1'b1;
        end else begin
          ibus_req_o  = 1'b1;
          ibus_addr_o = r_pc;
          if (ibus_ack_i) begin
            if_pc   = r_pc;
            if_inst = ibus_data_i;
          end else begin
            stallreq_o = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if_pc   = r_pc;
        if_inst = r_hold_inst;
      end
      S_DISCARD: begin
        ibus_req_o  = 1'b1;
        ibus_addr_o = r_disc_addr;
        stallreq_o  = 1'b1;
      end
      default: begin
        ibus_req_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: per-cycle vector table plus an
// instruction scoreboard, followed by reset-mid-request and misaligned-branch sequences.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] ibus_data_i;
  logic        ibus_ack_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_o;
`ifdef IF_ALIGN_CHECK_EN
  logic        exc;
`endif

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .ibus_data_i             (ibus_data_i),
    .ibus_ack_i              (ibus_ack_i),
    .ibus_req_o              (ibus_req_o),
    .ibus_addr_o             (ibus_addr_o),
    .if_pc                   (if_pc),
    .if_inst                 (if_inst),
    .stallreq_o              (stallreq_o)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .if_excepttype_o         (exc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [5:0]  stl;
    logic        fl;
    logic [31:0] npc;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] data;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_sr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic ack, input logic [5:0] stl, input logic fl,
                     input logic [31:0] npc, input logic br, input logic [31:0] tgt,
                     input logic [31:0] data, input logic e_req, input logic [31:0] e_addr,
                     input logic e_sr, input logic [31:0] e_pc, input logic [31:0] e_inst);
    vec_t v;
    v.ack = ack; v.stl = stl; v.fl = fl; v.npc = npc; v.br = br; v.tgt = tgt;
    v.data = data; v.e_req = e_req; v.e_addr = e_addr; v.e_sr = e_sr;
    v.e_pc = e_pc; v.e_inst = e_inst;
    vecs.push_back(v);
  endtask

  // Fetch at a with no ack this cycle.
  task automatic fw(input logic [31:0] a);
    add(1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,
        1'b1, a, 1'b1, 32'h0, 32'h0);
  endtask

  // Fetch at a acked this cycle, no stall.
  task automatic fk(input logic [31:0] a);
    add(1'b1, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, dat(a),
        1'b1, a, 1'b0, a, dat(a));
  endtask

  task automatic drive(input vec_t v);
    ibus_ack_i              = v.ack;
    ibus_data_i             = v.data;
    stall                   = v.stl;
    flush                   = v.fl;
    new_pc                  = v.npc;
    branch_flag_i           = v.br;
    branch_target_address_i = v.tgt;
  endtask

  initial begin
    vec_t v;
    sb_t  e;
    vec_t z;
    rst = 1'b0;
    z = '{ack: 1'b0, stl: 6'b0, fl: 1'b0, npc: 32'h0, br: 1'b0, tgt: 32'h0, data: 32'h0,
          e_req: 1'b0, e_addr: 32'h0, e_sr: 1'b0, e_pc: 32'h0, e_inst: 32'h0};
    drive(z);

    // Idle cycle, then 1-cycle-ack stream 0x0..0xC.
    add(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    fw(32'h0000_0000); fk(32'h0000_0000); fw(32'h0000_0004); fk(32'h0000_0004);
    fw(32'h0000_0008); fk(32'h0000_0008); fw(32'h0000_000C); fk(32'h0000_000C);
    // 0x10: ack three cycles late, acked under stall, then held.
    fw(32'h0000_0010); fw(32'h0000_0010); fw(32'h0000_0010);
    add(1'b1, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0, dat(32'h10),
        1'b1, 32'h0000_0010, 1'b0, 32'h0000_0010, dat(32'h10));
    add(1'b0, 6'b000011, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,
        1'b0, 32'h0, 1'b0, 32'h0000_0010, dat(32'h10));
    add(1'b0, 6'b000000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,
        1'b0, 32'h0, 1'b0, 32'h0000_0010, dat(32'h10));
    fw(32'h0000_0014); fk(32'h0000_0014); fw(32'h0000_0018); fk(32'h0000_0018);
    fw(32'h0000_001C); fk(32'h0000_001C); fw(32'h0000_0020); fk(32'h0000_0020);
    // Delay slot at 0x24 with branch to 0x100 seen before its ack.
    add(1'b0, 6'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0100, 32'h0,
        1'b1, 32'h0000_0024, 1'b1, 32'h0, 32'h0);
    fw(32'h0000_0024); fk(32'h0000_0024); fw(32'h0000_0100); fk(32'h0000_0100);
    // Flush with ack -> 0x30; flush without ack -> discard 0x30, go to 0x80.
    add(1'b1, 6'b0, 1'b1, 32'h0000_0030, 1'b0, 32'h0, dat(32'h104),
        1'b1, 32'h0000_0104, 1'b0, 32'h0000_0104, dat(32'h104));
    add(1'b0, 6'b0, 1'b1, 32'h0000_0080, 1'b0, 32'h0, 32'h0,
        1'b1, 32'h0000_0030, 1'b1, 32'h0, 32'h0);
    add(1'b0, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,
        1'b1, 32'h0000_0030, 1'b1, 32'h0, 32'h0);
    add(1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0, dat(32'h30),
        1'b1, 32'h0000_0030, 1'b1, 32'h0, 32'h0);
    fw(32'h0000_0080); fk(32'h0000_0080);
    // Second flush while discarding only moves the PC.
    add(1'b0, 6'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0, 32'h0,
        1'b1, 32'h0000_0084, 1'b1, 32'h0, 32'h0);
    add(1'b0, 6'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0, 32'h0,
        1'b1, 32'h0000_0084, 1'b1, 32'h0, 32'h0);
    add(1'b1, 6'b0, 1'b0, 32'h0, 1'b0, 32'h0, dat(32'h84),
        1'b1, 32'h0000_0084, 1'b1, 32'h0, 32'h0);
    fw(32'h0000_0300); fk(32'h0000_0300); fw(32'h0000_0304);
    // Branch on the ack cycle to the top word, then wrap to 0.
    add(1'b1, 6'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, dat(32'h304),
        1'b1, 32'h0000_0304, 1'b0, 32'h0000_0304, dat(32'h304));
    fk(32'hFFFF_FFFC);
    fw(32'h0000_0000);
    // Branch while ID is stalled must be ignored.
    add(1'b0, 6'b000100, 1'b0, 32'h0, 1'b1, 32'h0000_0500, 32'h0,
        1'b1, 32'h0000_0000, 1'b1, 32'h0, 32'h0);
    fk(32'h0000_0000); fw(32'h0000_0004);

    #2;
    chk("rst.req", 32'(ibus_req_o), 32'h0);
    chk("rst.addr", ibus_addr_o, 32'h0);
    chk("rst.pc", if_pc, 32'h0);
    chk("rst.inst", if_inst, 32'h0);
    chk("rst.stallreq", 32'(stallreq_o), 32'h0);
`ifdef IF_ALIGN_CHECK_EN
    chk("rst.exc", 32'(exc), 32'h0);
`endif
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v);
      if (v.ack && v.e_req && !v.e_sr) begin
        e.pc = v.e_pc;
        e.inst = v.e_inst;
        sb.push_back(e);
      end
      #4;
      chk($sformatf("v%0d.req", i), 32'(ibus_req_o), 32'(v.e_req));
      chk($sformatf("v%0d.addr", i), ibus_addr_o, v.e_addr);
      chk($sformatf("v%0d.stallreq", i), 32'(stallreq_o), 32'(v.e_sr));
      chk($sformatf("v%0d.if_pc", i), if_pc, v.e_pc);
      chk($sformatf("v%0d.if_inst", i), if_inst, v.e_inst);
`ifdef IF_ALIGN_CHECK_EN
      chk($sformatf("v%0d.exc", i), 32'(exc), 32'h0);
`endif
      if (ibus_ack_i && ibus_req_o && !stallreq_o) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb.unexpected: got pc %h inst %h expected no instruction", if_pc, if_inst);
        end else begin
          e = sb.pop_front();
          chk($sformatf("sb%0d.pc", i), if_pc, e.pc);
          chk($sformatf("sb%0d.inst", i), if_inst, e.inst);
        end
      end
      @(posedge clk); #1;
    end
    chk("sb.empty", 32'(sb.size()), 32'h0);

    // Reset asserted while a request is outstanding.
    drive(z);
    #4;
    chk("mid.req_before", 32'(ibus_req_o), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid.req", 32'(ibus_req_o), 32'h0);
    chk("mid.addr", ibus_addr_o, 32'h0);
    chk("mid.stallreq", 32'(stallreq_o), 32'h0);
    @(posedge clk); #1;
    chk("mid.req_held", 32'(ibus_req_o), 32'h0);
    rst = 1'b1;
    #4;
    chk("mid.idle_req", 32'(ibus_req_o), 32'h0);
    @(posedge clk); #1;
    #4;
    chk("mid.refetch_req", 32'(ibus_req_o), 32'h1);
    chk("mid.refetch_addr", ibus_addr_o, 32'h0);
    @(posedge clk); #1;

    // Branch to a misaligned target.
    ibus_ack_i = 1'b1;
    ibus_data_i = dat(32'h0);
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h0000_0102;
    #4;
    chk("mis.pre_inst", if_inst, dat(32'h0));
    @(posedge clk); #1;
    drive(z);
    #4;
`ifdef IF_ALIGN_CHECK_EN
    chk("mis.req", 32'(ibus_req_o), 32'h0);
    chk("mis.stallreq", 32'(stallreq_o), 32'h0);
    chk("mis.if_pc", if_pc, 32'h0000_0102);
    chk("mis.if_inst", if_inst, 32'h0);
    chk("mis.exc", 32'(exc), 32'h1);
`else
    chk("mis.req", 32'(ibus_req_o), 32'h1);
    chk("mis.addr", ibus_addr_o, 32'h0000_0102);
    chk("mis.stallreq", 32'(stallreq_o), 32'h1);
`endif
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
